player_position_ctrl: RTL and testbench

Parametrised player-position controller for the maze game, successor of the fixed-width move/increment logic. It accepts one direction request at a time over a valid/ready handshake and checks grid bounds. It then queries the maze wall memory, waiting a parametrised read latency, and commits or rejects the move. Sits between the keyboard/button decoder and the maze renderer/game-state FSM; also flags arrival at the goal cell.

---
 rtl/maze_pkg.sv | 17 +
 rtl/player_position_ctrl.sv | 149 ++++++++++++++
 tb/tb_player_position_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// Shared maze-game definitions: direction encoding and the position-controller state set.
package maze_pkg;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    QUERY,
    WAIT,
    RESP,
    GOAL
  } state_t;

endpackage

// File: rtl/player_position_ctrl.sv
// Player-position controller: takes one direction request at a time, checks grid bounds,
// asks the wall memory about the target cell and commits or rejects the move.
module player_position_ctrl
  import maze_pkg::*;
#(
  parameter int X_W         = 5,
  parameter int Y_W         = 5,
  parameter int MAX_X       = 19,
  parameter int MAX_Y       = 14,
  parameter int START_X     = 1,
  parameter int START_Y     = 1,
  parameter int GOAL_X      = 18,
  parameter int GOAL_Y      = 13,
  parameter int MEM_LATENCY = 2
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           move_valid,
  input  logic [1:0]     move_dir,
  output logic           move_ready,
  output logic           query_valid,
  output logic [X_W-1:0] query_x,
  output logic [Y_W-1:0] query_y,
  input  logic           wall_in,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           done,
  output logic           moved,
  output logic           blocked,
  output logic           at_goal
);

  localparam int  CNT_W         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam bit  GOAL_AT_START = (START_X == GOAL_X) && (START_Y == GOAL_Y);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [X_W-1:0]   next_x;
  logic [Y_W-1:0]   next_y;
  logic             oob;

  // Bounds are tested before the +/-1 is used, so the wrapped value never leaves this block.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_x = pos_x;
    next_y = pos_y;
    oob    = 1'b0;
    unique case (move_dir)
      DIR_LEFT: begin
        oob    = (pos_x == '0);
        next_x = pos_x - X_W'(1);
      end
      DIR_RIGHT: begin
        oob    = (pos_x == X_W'(MAX_X));
        next_x = pos_x + X_W'(1);
      end
      DIR_UP: begin
        oob    = (pos_y == '0);
        next_y = pos_y - Y_W'(1);
      end
      DIR_DOWN: begin
        oob    = (pos_y == Y_W'(MAX_Y));
        next_y = pos_y + Y_W'(1);
      end
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      pos_x       <= X_W'(START_X);
      pos_y       <= Y_W'(START_Y);
      query_x     <= '0;
      query_y     <= '0;
      cnt         <= '0;
      move_ready  <= 1'b1;
      query_valid <= 1'b0;
      done        <= 1'b0;
      moved       <= 1'b0;
      blocked     <= 1'b0;
      at_goal     <= GOAL_AT_START;
    end else begin
      query_valid <= 1'b0;
      done        <= 1'b0;
      moved       <= 1'b0;
      blocked     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (move_valid && move_ready) begin
            move_ready <= 1'b0;
            if (oob) begin
              state   <= RESP;
              done    <= 1'b1;
              blocked <= 1'b1;
            end else begin
              state       <= QUERY;
              query_valid <= 1'b1;
              query_x     <= next_x;
              query_y     <= next_y;
              cnt         <= CNT_W'(MEM_LATENCY - 1);
            end
          end
        end

        // The query cycle counts as the first latency cycle.
        QUERY: begin
          state <= WAIT;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end

        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            done  <= 1'b1;
            if (wall_in) begin
              blocked <= 1'b1;
            end else begin
              moved <= 1'b1;
              pos_x <= query_x;
              pos_y <= query_y;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          if (pos_x == X_W'(GOAL_X) && pos_y == Y_W'(GOAL_Y)) begin
            state   <= GOAL;
            at_goal <= 1'b1;
          end else begin
            state      <= IDLE;
            move_ready <= 1'b1;
          end
        end

        GOAL: state <= GOAL;

        default: begin
          state      <= IDLE;
          move_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_position_ctrl.sv
// Scoreboard bench for player_position_ctrl: tracks the player in a bench model and
// compares each finished request against the expected outcome queued when it was issued.
module tb_player_position_ctrl;
  import maze_pkg::*;

  localparam int X_W         = 5;
  localparam int Y_W         = 5;
  localparam int MAX_X       = 19;
  localparam int MAX_Y       = 14;
  localparam int START_X     = 1;
  localparam int START_Y     = 1;
  localparam int GOAL_X      = 18;
  localparam int GOAL_Y      = 13;
  localparam int MEM_LATENCY = 2;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           move_valid = 1'b0;
  logic [1:0]     move_dir = 2'd0;
  logic           wall_in = 1'b0;
  logic           move_ready;
  logic           query_valid;
  logic [X_W-1:0] query_x;
  logic [Y_W-1:0] query_y;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           done;
  logic           moved;
  logic           blocked;
  logic           at_goal;

  typedef struct packed {
    logic           moved;
    logic           blocked;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mx, my;
  bit   mgoal;

  always #5 clock = ~clock;

  player_position_ctrl #(
    .X_W(X_W), .Y_W(Y_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
    .START_X(START_X), .START_Y(START_Y), .GOAL_X(GOAL_X), .GOAL_Y(GOAL_Y),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clock(clock), .resetn(resetn),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y), .wall_in(wall_in),
    .pos_x(pos_x), .pos_y(pos_y),
    .done(done), .moved(moved), .blocked(blocked), .at_goal(at_goal)
  );

  task automatic apply_reset();
    @(negedge clock);
    resetn     = 1'b0;
    move_valid = 1'b0;
    wall_in    = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    mx     = START_X;
    my     = START_Y;
    mgoal  = 1'b0;
    sb.delete();
  endtask

  // Issues one request, plays the wall memory, and scores the outcome when done appears.
  task automatic do_move(input logic [1:0] dir, input logic wall, input string tag);
    int   tx, ty, qcount, wcyc;
    bit   oob, seen_done;
    exp_t e, got;
    tx = mx;
    ty = my;
    oob = 1'b0;
    case (dir)
      DIR_LEFT:  if (mx == 0)     oob = 1'b1; else tx = mx - 1;
      DIR_RIGHT: if (mx == MAX_X) oob = 1'b1; else tx = mx + 1;
      DIR_UP:    if (my == 0)     oob = 1'b1; else ty = my - 1;
      default:   if (my == MAX_Y) oob = 1'b1; else ty = my + 1;
    endcase
    e.moved   = !oob && !wall;
    e.blocked = oob || wall;
    e.x       = e.moved ? X_W'(tx) : X_W'(mx);
    e.y       = e.moved ? Y_W'(ty) : Y_W'(my);
    sb.push_back(e);

    @(negedge clock);
    checks++;
    if (move_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b want 1", tag, move_ready);
    end
    move_valid = 1'b1;
    move_dir   = dir;
    @(posedge clock);
    #1 move_valid = 1'b0;

    qcount    = 0;
    wcyc      = -1;
    seen_done = 1'b0;
    for (int c = 1; c <= MEM_LATENCY + 6 && !seen_done; c++) begin
      @(negedge clock);
      if (query_valid === 1'b1) begin
        qcount++;
        checks++;
        if (oob || c != 1 || query_x !== X_W'(tx) || query_y !== Y_W'(ty)) begin
          errors++;
          $display("FAIL %s query: cycle %0d at (%0d,%0d), want cycle 1 at (%0d,%0d), oob=%0d",
                   tag, c, query_x, query_y, tx, ty, oob);
        end
        wcyc = c + MEM_LATENCY - 1;
      end
      wall_in = (c == wcyc) ? wall : ~wall;
      if (done !== 1'b1 && (moved === 1'b1 || blocked === 1'b1)) begin
        checks++;
        errors++;
        $display("FAIL %s qualifier_without_done: cycle %0d moved=%b blocked=%b", tag, c, moved, blocked);
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        got = '{moved, blocked, pos_x, pos_y};
        e   = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s result: got moved=%b blocked=%b pos=(%0d,%0d) want moved=%b blocked=%b pos=(%0d,%0d)",
                   tag, got.moved, got.blocked, got.x, got.y, e.moved, e.blocked, e.x, e.y);
        end
        checks++;
        if (c != (oob ? 1 : MEM_LATENCY + 1)) begin
          errors++;
          $display("FAIL %s done_cycle: got %0d want %0d", tag, c, oob ? 1 : MEM_LATENCY + 1);
        end
      end
    end
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, MEM_LATENCY + 6);
      void'(sb.pop_front());
    end
    checks++;
    if (qcount != (oob ? 0 : 1)) begin
      errors++;
      $display("FAIL %s query_count: got %0d want %0d", tag, qcount, oob ? 0 : 1);
    end

    if (e.moved) begin
      mx = tx;
      my = ty;
      if (mx == GOAL_X && my == GOAL_Y) mgoal = 1'b1;
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || moved !== 1'b0 || blocked !== 1'b0 ||
        at_goal !== mgoal || move_ready !== !mgoal) begin
      errors++;
      $display("FAIL %s after_done: done=%b moved=%b blocked=%b at_goal=%b ready=%b want 0 0 0 %b %b",
               tag, done, moved, blocked, at_goal, move_ready, mgoal, !mgoal);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clock);
    checks++;
    if (pos_x !== X_W'(START_X) || pos_y !== Y_W'(START_Y)) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", pos_x, pos_y, START_X, START_Y);
    end
    checks++;
    if (move_ready !== 1'b1 || done !== 1'b0 || query_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b query_valid=%b want 1 0 0", move_ready, done, query_valid);
    end
    checks++;
    if (at_goal !== 1'b0) begin
      errors++;
      $display("FAIL reset_goal: got %b want 0", at_goal);
    end
  endtask

  task automatic test_basic_moves();
    apply_reset();
    do_move(DIR_RIGHT, 1'b0, "right_open");
    apply_reset();
    do_move(DIR_DOWN, 1'b1, "down_wall");
    do_move(DIR_LEFT, 1'b1, "left_wall");
    do_move(DIR_UP, 1'b0, "up_open");
  endtask

  task automatic test_bounds();
    apply_reset();
    do_move(DIR_LEFT, 1'b0, "to_x0");
    do_move(DIR_UP, 1'b0, "to_y0");
    do_move(DIR_LEFT, 1'b0, "oob_left");
    do_move(DIR_UP, 1'b0, "oob_up");
    for (int i = 0; i < MAX_Y; i++) do_move(DIR_DOWN, 1'b0, "walk_down");
    do_move(DIR_DOWN, 1'b0, "oob_down");
    for (int i = 0; i < MAX_X; i++) do_move(DIR_RIGHT, 1'b0, "walk_right");
    do_move(DIR_RIGHT, 1'b0, "oob_right");
    do_move(DIR_RIGHT, 1'b1, "oob_right_wall");
  endtask

  task automatic test_goal();
    apply_reset();
    for (int i = 0; i < 16; i++) do_move(DIR_RIGHT, 1'b0, "goal_walk_x");
    do_move(DIR_DOWN, 1'b1, "goal_wall");
    for (int i = 0; i < 12; i++) do_move(DIR_DOWN, 1'b0, "goal_walk_y");
    do_move(DIR_RIGHT, 1'b0, "enter_goal");
    move_valid = 1'b1;
    move_dir   = DIR_LEFT;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++;
      if (move_ready !== 1'b0 || query_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL goal_lock: cycle %0d ready=%b query_valid=%b done=%b want 0 0 0",
                 c, move_ready, query_valid, done);
      end
    end
    move_valid = 1'b0;
    checks++;
    if (pos_x !== X_W'(GOAL_X) || pos_y !== Y_W'(GOAL_Y) || at_goal !== 1'b1) begin
      errors++;
      $display("FAIL goal_hold: pos=(%0d,%0d) at_goal=%b want (%0d,%0d) 1", pos_x, pos_y, at_goal, GOAL_X, GOAL_Y);
    end
  endtask

  task automatic test_reset_in_wait();
    int qcount, dcount;
    apply_reset();
    @(negedge clock);
    move_valid = 1'b1;
    move_dir   = DIR_RIGHT;
    wall_in    = 1'b1;
    @(negedge clock);
    checks++;
    if (query_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_query: got %b want 1", query_valid);
    end
    @(negedge clock);
    resetn     = 1'b0;
    move_valid = 1'b0;
    wall_in    = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    qcount = 0;
    dcount = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (query_valid === 1'b1) qcount++;
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (qcount != 0 || dcount != 0) begin
      errors++;
      $display("FAIL rst_wait_pulses: query=%0d done=%0d want 0 0", qcount, dcount);
    end
    checks++;
    if (pos_x !== X_W'(START_X) || pos_y !== Y_W'(START_Y) || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_state: pos=(%0d,%0d) ready=%b want (%0d,%0d) 1",
               pos_x, pos_y, move_ready, START_X, START_Y);
    end
  endtask

  task automatic test_back_to_back();
    int qcount, dcount, ready_hi;
    apply_reset();
    @(negedge clock);
    move_valid = 1'b1;
    move_dir   = DIR_RIGHT;
    wall_in    = 1'b0;
    qcount   = 0;
    dcount   = 0;
    ready_hi = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (query_valid === 1'b1) qcount++;
      if (done === 1'b1) dcount++;
      if (c <= MEM_LATENCY + 1 && move_ready !== 1'b0) ready_hi++;
      if (c == MEM_LATENCY + 1) move_valid = 1'b0;
    end
    checks++;
    if (qcount != 1 || dcount != 1) begin
      errors++;
      $display("FAIL held_valid_pulses: query=%0d done=%0d want 1 1", qcount, dcount);
    end
    checks++;
    if (ready_hi != 0) begin
      errors++;
      $display("FAIL held_valid_ready: ready high in %0d busy cycles, want 0", ready_hi);
    end
    checks++;
    if (pos_x !== X_W'(START_X + 1) || pos_y !== Y_W'(START_Y)) begin
      errors++;
      $display("FAIL held_valid_pos: got (%0d,%0d) want (%0d,%0d)", pos_x, pos_y, START_X + 1, START_Y);
    end
    mx = START_X + 1;
    my = START_Y;
    do_move(DIR_RIGHT, 1'b0, "next_accept");
    do_move(DIR_LEFT, 1'b1, "next_wall");
  endtask

  initial begin
    test_reset();
    test_basic_moves();
    test_bounds();
    test_goal();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
